// File: rtl/rtr_op_sw_arbiter.sv
// Per-output-port switch arbiter: round-robin among inputs whose route selects this
// output, wormhole locking from head to tail flit, and downstream credit tracking.
// Optional credit-stall statistic enabled by RTR_OP_SW_ARBITER_STALL_STATS_EN.
module rtr_op_sw_arbiter #(
    parameter int unsigned num_ports   = 5,
    parameter int unsigned buffer_size = 8,
    parameter int unsigned port_id     = 0,
    localparam int unsigned PW = (num_ports > 1) ? $clog2(num_ports) : 1,
    localparam int unsigned CW = $clog2(buffer_size + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:num_ports-1] req_ip,
    input  logic [0:num_ports-1] req_head,
    input  logic [0:num_ports-1] req_tail,
    input  logic                 credit_in,
    output logic [0:num_ports-1] gnt_ip,
    output logic                 flit_valid,
    output logic                 locked,
    output logic [0:num_ports-1] lock_ip,
    output logic [CW-1:0]        credit_count,
    output logic [15:0]          stall_count,
    output logic [0:1]           errors
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic [0:1]           errors_q;
    logic [0:num_ports-1] eff_req;
    logic [0:num_ports-1] gnt;
    logic [PW-1:0]        win, cand;
    logic                 found;
    logic                 grant_en;
    logic                 frame_err;
    logic                 credit_ovf;
    int                   search_idx;

    // Own-port requests are never served.
    always_comb begin
        eff_req          = req_ip;
        eff_req[port_id] = 1'b0;
    end

    // Grants are suppressed while reset is held or no downstream slot is free.
    assign grant_en = reset && (credit_q != '0);

    // Round-robin search: first requester at or after the pointer, with wrap.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        cand       = '0;
        search_idx = 0;
        for (int k = 0; k < int'(num_ports); k++) begin
            search_idx = (int'(ptr_q) + k) % int'(num_ports);
            cand       = PW'(search_idx);
            if (!found && eff_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state, grant and framing-error decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt       = '0;
        frame_err = req_ip[port_id];
        unique case (state_q)
            StIdle: begin
                if (grant_en && found) begin
                    gnt[win] = 1'b1;
                    ptr_d    = (win == PW'(num_ports - 1)) ? '0 : win + PW'(1);
                    if (!req_head[win]) begin
                        frame_err = 1'b1;
                    end else if (!req_tail[win]) begin
                        state_d = StLocked;
                        owner_d = win;
                    end
                end
            end
            StLocked: begin
                if (grant_en && eff_req[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                    if (req_head[owner_q]) frame_err = 1'b1;
                    if (req_tail[owner_q]) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit bookkeeping; a return at full count is dropped and flagged.
    always_comb begin
        credit_d   = credit_q;
        credit_ovf = 1'b0;
        if ((|gnt) && !credit_in) begin
            credit_d = credit_q - CW'(1);
        end else if (!(|gnt) && credit_in) begin
            if (credit_q == CW'(buffer_size)) credit_ovf = 1'b1;
            else                              credit_d   = credit_q + CW'(1);
        end
    end

    // State, pointer, credit and error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            credit_q <= CW'(buffer_size);
            errors_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            errors_q <= {credit_ovf, frame_err};
        end
    end

    // One-hot owner view, only while a packet holds the output.
    always_comb begin
        lock_ip = '0;
        if (state_q == StLocked) lock_ip[owner_q] = 1'b1;
    end

    assign gnt_ip       = gnt;
    assign flit_valid   = |gnt;
    assign locked       = (state_q == StLocked);
    assign credit_count = credit_q;
    assign errors       = errors_q;

`ifdef RTR_OP_SW_ARBITER_STALL_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where someone wants the output but credits are exhausted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((|eff_req) && (credit_q == '0) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rtr_op_sw_arbiter.sv
// Self-checking bench for rtr_op_sw_arbiter: directed scenarios plus random traffic,
// all compared against a behavioural model of the arbitration/credit rules.
module tb_rtr_op_sw_arbiter;

    localparam int NP  = 5;
    localparam int BS  = 8;
    localparam int PID = 4;
    localparam int CW  = $clog2(BS + 1);

    logic          clk;
    logic          reset;
    logic [0:NP-1] req_ip, req_head, req_tail;
    logic          credit_in;
    logic [0:NP-1] gnt_ip;
    logic          flit_valid;
    logic          locked;
    logic [0:NP-1] lock_ip;
    logic [CW-1:0] credit_count;
    logic [15:0]   stall_count;
    logic [0:1]    errors;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_owner;   // -1 when no packet holds the output
    int m_ptr;
    int m_cred;
    int m_stall;
    bit m_ovf;
    bit m_ferr;

    rtr_op_sw_arbiter #(
        .num_ports  (NP),
        .buffer_size(BS),
        .port_id    (PID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_ip      (req_ip),
        .req_head    (req_head),
        .req_tail    (req_tail),
        .credit_in   (credit_in),
        .gnt_ip      (gnt_ip),
        .flit_valid  (flit_valid),
        .locked      (locked),
        .lock_ip     (lock_ip),
        .credit_count(credit_count),
        .stall_count (stall_count),
        .errors      (errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cred  = BS;
        m_stall = 0;
        m_ovf   = 1'b0;
        m_ferr  = 1'b0;
    endfunction

    // Drive one cycle's inputs (called at a falling edge), check, advance the model.
    task automatic run_cycle(input logic [0:NP-1] rq, input logic [0:NP-1] hd,
                             input logic [0:NP-1] tl, input logic ci);
        logic [0:NP-1] eff;
        logic [0:NP-1] exp_gnt;
        logic [0:NP-1] exp_lock;
        bit            ferr;
        bit            ovf;
        int            w;
        req_ip    = rq;
        req_head  = hd;
        req_tail  = tl;
        credit_in = ci;
        #1;
        eff      = rq;
        eff[PID] = 1'b0;
        exp_gnt  = '0;
        exp_lock = '0;
        if (m_owner >= 0) exp_lock[m_owner] = 1'b1;
        ferr = rq[PID];
        w    = -1;
        if (m_cred > 0) begin
            if (m_owner < 0) begin
                for (int k = 0; k < NP; k++) begin
                    if (w < 0 && eff[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
                end
            end else if (eff[m_owner]) begin
                w = m_owner;
            end
        end
        if (w >= 0) exp_gnt[w] = 1'b1;

        chk("gnt", 32'(gnt_ip), 32'(exp_gnt));
        chk("valid", 32'(flit_valid), 32'(|exp_gnt));
        chk("locked", 32'(locked), 32'(m_owner >= 0));
        chk("lock_ip", 32'(lock_ip), 32'(exp_lock));
        chk("credit", 32'(credit_count), 32'(m_cred));
`ifdef RTR_OP_SW_ARBITER_STALL_STATS_EN
        chk("stall", 32'(stall_count), 32'(m_stall));
`else
        chk("stall", 32'(stall_count), 32'd0);
`endif
        chk("err_ovf", 32'(errors[0]), 32'(m_ovf));
        chk("err_frame", 32'(errors[1]), 32'(m_ferr));

        // Advance model to the next cycle.
        if ((|eff) && m_cred == 0 && m_stall < 65535) m_stall++;
        if (w >= 0) begin
            if (m_owner < 0) begin
                m_ptr = (w + 1) % NP;
                if (!hd[w])      ferr = 1'b1;
                else if (!tl[w]) m_owner = w;
            end else begin
                if (hd[w]) ferr = 1'b1;
                if (tl[w]) m_owner = -1;
            end
        end
        ovf = 1'b0;
        if (w >= 0 && !ci) begin
            m_cred--;
        end else if (w < 0 && ci) begin
            if (m_cred == BS) ovf = 1'b1;
            else              m_cred++;
        end
        m_ovf  = ovf;
        m_ferr = ferr;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_ip    = '0;
        req_head  = '0;
        req_tail  = '0;
        credit_in = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_cred", 32'(credit_count), 32'(BS));
        chk("rst_err", 32'(errors), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [0:NP-1] rq, hd, tl;
        do_reset();

        // Round-robin fairness: inputs 0,1,2 with single-flit packets.
        for (int i = 0; i < 6; i++) run_cycle(5'b11100, 5'b11111, 5'b11111, 1'b0);
        chk("fair_cred", 32'(credit_count), 32'd2);

        // Wormhole lock: input 1 sends head/body/tail, input 3 waits.
        do_reset();
        run_cycle(5'b01010, 5'b01010, 5'b00010, 1'b0);
        chk("worm_lock", 32'(locked), 32'd1);
        chk("worm_lock_ip", 32'(lock_ip), 32'(5'b01000));
        run_cycle(5'b01010, 5'b00010, 5'b00010, 1'b0);
        run_cycle(5'b01010, 5'b00010, 5'b01010, 1'b0);
        chk("worm_lock_tail", 32'(locked), 32'd0);
        run_cycle(5'b00010, 5'b00010, 5'b00010, 1'b0);
        chk("worm_cred", 32'(credit_count), 32'd4);

        // Credit exhaustion: drain to 2, then a 4-flit packet from input 0.
        do_reset();
        for (int i = 0; i < 6; i++) run_cycle(5'b01000, 5'b01000, 5'b01000, 1'b0);
        run_cycle(5'b10000, 5'b10000, 5'b00000, 1'b0);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b0);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b0);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b0);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b1);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b0);
`ifdef RTR_OP_SW_ARBITER_STALL_STATS_EN
        chk("exh_stall", 32'(stall_count), 32'd3);
`else
        chk("exh_stall", 32'(stall_count), 32'd0);
`endif
        run_cycle(5'b10000, 5'b00000, 5'b10000, 1'b1);
        run_cycle(5'b10000, 5'b00000, 5'b10000, 1'b0);
        chk("exh_unlock", 32'(locked), 32'd0);
        // Simultaneous grant and credit at count 1.
        run_cycle(5'b00000, 5'b00000, 5'b00000, 1'b1);
        run_cycle(5'b10000, 5'b10000, 5'b10000, 1'b1);
        chk("sim_cred", 32'(credit_count), 32'd1);

        // Error paths.
        do_reset();
        run_cycle(5'b00000, 5'b00000, 5'b00000, 1'b1);
        chk("ovf_err", 32'(errors[0]), 32'd1);
        chk("ovf_cred", 32'(credit_count), 32'(BS));
        run_cycle(5'b00000, 5'b00000, 5'b00000, 1'b0);
        chk("ovf_pulse", 32'(errors[0]), 32'd0);
        run_cycle(5'b10000, 5'b00000, 5'b00000, 1'b0);
        chk("headless_err", 32'(errors[1]), 32'd1);
        run_cycle(5'b00001, 5'b00001, 5'b00001, 1'b0);
        chk("own_port_err", 32'(errors[1]), 32'd1);

        // Reset mid-packet while locked to input 2 with 5 credits.
        do_reset();
        run_cycle(5'b10000, 5'b10000, 5'b10000, 1'b0);
        run_cycle(5'b01000, 5'b01000, 5'b01000, 1'b0);
        run_cycle(5'b00100, 5'b00100, 5'b00000, 1'b0);
        chk("pre_rst_cred", 32'(credit_count), 32'd5);
        chk("pre_rst_lock", 32'(lock_ip), 32'(5'b00100));
        req_ip   = 5'b00100;
        req_head = 5'b00000;
        req_tail = 5'b00000;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_cred", 32'(credit_count), 32'(BS));
        chk("mid_rst_gnt", 32'(gnt_ip), 32'd0);
        chk("mid_rst_lock_ip", 32'(lock_ip), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        // Pointer back at 0: everyone requesting gives input 0.
        run_cycle(5'b11110, 5'b11110, 5'b11110, 1'b0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rq = NP'($urandom) & NP'($urandom);
            hd = NP'($urandom);
            tl = NP'($urandom);
            if ($urandom_range(0, 3) == 0) rq[PID] = 1'b0;
            run_cycle(rq, hd, tl, ($urandom_range(0, 9) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
